mem_req_queue: RTL and testbench
================================

MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 Parameter: DEST_W, 5, destination-register tag width carried with each load.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid_in  input  1  pipeline presents a load/store this cycle.
REQ-005 req_rw_in  input  1  1 = store, 0 = load.
REQ-006 req_addr_in / req_data_in  input  32 / 32  request address / store data.
REQ-007 req_dest_in  input  DEST_W  load destination tag (ignored for stores).
REQ-008 req_ready_out  output  1  queue accepts a request this cycle.
REQ-009 mem_addr_out / mem_data_out  output  32 / 32  to memory_system addr_in / data_in.
REQ-010 mem_rw_out  output  1  to memory_system rw_in.
REQ-011 mem_id_out  output  4  to memory_system id_in; equals queue slot index.
REQ-012 mem_valid_out  output  1  to memory_system valid_in.
REQ-013 mem_stall_in  input  1  from memory_system stall_out.
REQ-014 mem_data_in / mem_id_in / mem_ready_in  input  32 / 4 / 1  from memory_system data_out / id_out / ready_out.
REQ-015 wb_valid_out / wb_dest_out / wb_data_out  output  1 / DEST_W / 32  retired-load writeback.
REQ-016 count_out  output  5  occupied slots, 0..16.
REQ-017 err_out  output  1  sticky protocol-error flag.

Function
REQ-018 16 slots; per slot: valid, rw, addr, data, dest, issued, done, rdata.
REQ-019 Three 4-bit pointers: tail (alloc), iss (issue), head (retire); all wrap 15->0; full/empty decided by count, never by pointer equality alone.
REQ-020 req_ready_out = (count < 16), from registered count only; at count 16 no accept even if a retire occurs that cycle.
REQ-021 Accept when req_valid_in && req_ready_out: write slot[tail], valid=1, issued=0, done=0; tail+1.
REQ-022 Issue strictly in allocation order; mem_valid_out = (slot[iss] valid && !issued) && !mem_stall_in, combinational; mem_* outputs driven from slot[iss].
REQ-023 When mem_valid_out=1: slot[iss].issued=1, iss+1; an entry accepted in cycle N is issuable no earlier than cycle N+1.
REQ-024 mem_stall_in=1 forces mem_valid_out=0 and holds iss.
REQ-025 mem_ready_in=1: if slot[mem_id_in] valid && issued && !done -> done=1, rdata=mem_data_in; otherwise ignore and set err_out.
REQ-026 Retire in order, max one per cycle: if slot[head] valid && done -> valid=0, head+1.
REQ-027 Retired load: next cycle wb_valid_out=1 for exactly one cycle with wb_dest_out=dest, wb_data_out=rdata; retired store: no writeback pulse.
REQ-028 Response to head in cycle N -> retire in N+1 -> wb_valid_out in N+2 (min response-to-writeback latency 2).
REQ-029 Simultaneous accept and retire: count unchanged; accept only, +1; retire only, -1.
REQ-030 Out-of-order responses allowed; younger completed entries wait behind an incomplete head.
REQ-031 No store-to-load forwarding; ordering guaranteed solely by in-order issue.
REQ-032 err_out, once set, holds until reset.

Reset
REQ-033 reset_n low asynchronously clears all slot valid/issued/done bits, pointers, count, wb_valid_out, err_out; mem_valid_out=0.
REQ-034 After release: req_ready_out=1, count_out=0, wb_valid_out=0, err_out=0.
REQ-035 Reset mid-operation discards all in-flight entries without writeback; later responses to cleared slots set err_out.

Verification
REQ-036 Load addr 0x40 dest 3, memory replies id 0 data 0xDEADBEEF two cycles after issue -> single wb pulse dest 3 data 0xDEADBEEF, count returns 0.
REQ-037 Push 16 requests, no responses -> req_ready_out=0 at count 16; 17th request held; one response on head -> ready returns after retire.
REQ-038 Issue loads ids 0,1,2; respond 2,1,0 -> writebacks strictly in order 0,1,2.
REQ-039 Hold mem_stall_in high 5 cycles with 3 queued -> mem_valid_out=0 throughout, then ids issued back-to-back in order.
REQ-040 Run 40 requests so pointers wrap twice -> mem_id_out sequence 0..15,0..15,0..7, all writebacks correct.
REQ-041 Response with id of empty slot, and reset with 4 in flight -> err_out=1 sticky; post-reset count_out=0, no writebacks.

Source files
------------

// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if
//   Bundles the request, memory-system and writeback signals of the
//   in-order memory request queue.
//   slave  : the queue side (takes requests and responses, drives memory
//            requests, writebacks, occupancy and the error flag).
//   master : the environment side (pipeline + memory system).
//   Signal groups:
//     req_*  pipeline -> queue load/store request, req_ready_out back
//     mem_*  queue <-> memory_system issue and response channel
//     wb_*   retired-load writeback
//     count_out / err_out  occupancy and sticky protocol-error flag
interface mem_req_queue_if #(
    parameter int DEST_W = 5
);
    logic              req_valid_in;
    logic              req_rw_in;
    logic [31:0]       req_addr_in;
    logic [31:0]       req_data_in;
    logic [DEST_W-1:0] req_dest_in;
    logic              req_ready_out;

    logic [31:0]       mem_addr_out;
    logic [31:0]       mem_data_out;
    logic              mem_rw_out;
    logic [3:0]        mem_id_out;
    logic              mem_valid_out;
    logic              mem_stall_in;
    logic [31:0]       mem_data_in;
    logic [3:0]        mem_id_in;
    logic              mem_ready_in;

    logic              wb_valid_out;
    logic [DEST_W-1:0] wb_dest_out;
    logic [31:0]       wb_data_out;
    logic [4:0]        count_out;
    logic              err_out;

    modport slave (
        input  req_valid_in, req_rw_in, req_addr_in, req_data_in, req_dest_in,
        output req_ready_out,
        output mem_addr_out, mem_data_out, mem_rw_out, mem_id_out, mem_valid_out,
        input  mem_stall_in, mem_data_in, mem_id_in, mem_ready_in,
        output wb_valid_out, wb_dest_out, wb_data_out, count_out, err_out
    );

    modport master (
        output req_valid_in, req_rw_in, req_addr_in, req_data_in, req_dest_in,
        input  req_ready_out,
        input  mem_addr_out, mem_data_out, mem_rw_out, mem_id_out, mem_valid_out,
        output mem_stall_in, mem_data_in, mem_id_in, mem_ready_in,
        input  wb_valid_out, wb_dest_out, wb_data_out, count_out, err_out
    );
endinterface

// File: rtl/mem_req_queue.sv
// mem_req_queue
//   16-entry in-order load/store queue between the pipeline and the memory
//   system. Requests are allocated at tail, issued strictly in allocation
//   order at iss, may complete out of order (tagged by slot index), and
//   retire in order at head with a one-cycle writeback pulse for loads.
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      mem_req_queue_if.slave (request, memory, writeback, status)
module mem_req_queue #(
    parameter int DEST_W = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_req_queue_if.slave bus
);
    localparam int DEPTH = 16;

    // Per-slot control bits (reset) and pointers.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  issued_q, issued_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [3:0]        tail_q, tail_d;
    logic [3:0]        iss_q, iss_d;
    logic [3:0]        head_q, head_d;
    logic [4:0]        count_q, count_d;
    logic              err_q, err_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DEST_W-1:0] wb_dest_q, wb_dest_d;
    logic [31:0]       wb_data_q, wb_data_d;

    // Per-slot payload; only meaningful while the slot is valid, so no reset.
    logic              rw_q    [DEPTH];
    logic [31:0]       addr_q  [DEPTH];
    logic [31:0]       data_q  [DEPTH];
    logic [31:0]       rdata_q [DEPTH];
    logic [DEST_W-1:0] dest_q  [DEPTH];

    logic ready;
    logic accept;
    logic issue;
    logic retire;
    logic resp_ok;

    // Occupancy never exceeds 16, so bit 4 set means exactly full. Readiness
    // looks only at the registered count: a retire in the same cycle does
    // not open a slot until the next cycle.
    always_comb begin
        ready   = ~count_q[4];
        accept  = bus.req_valid_in & ready;
        issue   = valid_q[iss_q] & ~issued_q[iss_q] & ~bus.mem_stall_in;
        retire  = valid_q[head_q] & done_q[head_q];
        resp_ok = bus.mem_ready_in & valid_q[bus.mem_id_in]
                & issued_q[bus.mem_id_in] & ~done_q[bus.mem_id_in];
    end

    always_comb begin
        valid_d    = valid_q;
        issued_d   = issued_q;
        done_d     = done_q;

        if (retire) begin
            valid_d[head_q] = 1'b0;
        end
        if (resp_ok) begin
            done_d[bus.mem_id_in] = 1'b1;
        end
        if (issue) begin
            issued_d[iss_q] = 1'b1;
        end
        // The tail slot can only coincide with head when empty or full, and
        // neither case allows both an accept and a retire, so no conflict.
        if (accept) begin
            valid_d[tail_q]  = 1'b1;
            issued_d[tail_q] = 1'b0;
            done_d[tail_q]   = 1'b0;
        end

        tail_d  = tail_q + 4'(accept);
        iss_d   = iss_q + 4'(issue);
        head_d  = head_q + 4'(retire);
        count_d = count_q + 5'(accept) - 5'(retire);

        // Any response that does not match an outstanding issued entry is a
        // protocol error; the flag is sticky until reset.
        err_d = err_q | (bus.mem_ready_in & ~resp_ok);

        // Writeback is registered: the retire cycle captures the head entry.
        wb_valid_d = retire & ~rw_q[head_q];
        wb_dest_d  = retire ? dest_q[head_q]  : wb_dest_q;
        wb_data_d  = retire ? rdata_q[head_q] : wb_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            tail_q     <= '0;
            iss_q      <= '0;
            head_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            issued_q   <= issued_d;
            done_q     <= done_d;
            tail_q     <= tail_d;
            iss_q      <= iss_d;
            head_q     <= head_d;
            count_q    <= count_d;
            err_q      <= err_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rw_q[tail_q]   <= bus.req_rw_in;
            addr_q[tail_q] <= bus.req_addr_in;
            data_q[tail_q] <= bus.req_data_in;
            dest_q[tail_q] <= bus.req_dest_in;
        end
        if (resp_ok) begin
            rdata_q[bus.mem_id_in] <= bus.mem_data_in;
        end
    end

    assign bus.req_ready_out = ready;
    assign bus.mem_valid_out = issue;
    assign bus.mem_id_out    = iss_q;
    assign bus.mem_addr_out  = addr_q[iss_q];
    assign bus.mem_data_out  = data_q[iss_q];
    assign bus.mem_rw_out    = rw_q[iss_q];
    assign bus.wb_valid_out  = wb_valid_q;
    assign bus.wb_dest_out   = wb_dest_q;
    assign bus.wb_data_out   = wb_data_q;
    assign bus.count_out     = count_q;
    assign bus.err_out       = err_q;
endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;
    localparam int DEST_W = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_queue_if #(.DEST_W(DEST_W)) bus ();
    mem_req_queue #(.DEST_W(DEST_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    typedef struct {
        bit                v;
        bit                rw;
        logic [31:0]       addr;
        logic [31:0]       data;
        logic [DEST_W-1:0] dest;
        bit                stall;
        bit                rdy;
        logic [3:0]        id;
        logic [31:0]       rdata;
    } stim_t;

    // Reference model entry: queue position is allocation order.
    typedef struct {
        bit                rw;
        logic [31:0]       addr;
        logic [31:0]       data;
        logic [DEST_W-1:0] dest;
        logic [3:0]        slot;
        bit                issued;
        bit                done;
        logic [31:0]       rdata;
    } ment_t;

    typedef struct {
        bit                v;
        bit                rw;
        logic [31:0]       addr;
        logic [31:0]       data;
        logic [DEST_W-1:0] dest;
        bit                rdy;
        logic [3:0]        id;
        logic [31:0]       rdata;
        bit                e_ready;
        bit                e_mv;
        logic [3:0]        e_id;
        logic [31:0]       e_addr;
        bit                e_wb;
        logic [DEST_W-1:0] e_dest;
        logic [31:0]       e_wdata;
        logic [4:0]        e_cnt;
    } tv_t;

    tv_t tv[12];

    ment_t             mq[$];
    int                alloc_cnt;
    bit                m_wb_v;
    logic [DEST_W-1:0] m_wb_dest;
    logic [31:0]       m_wb_data;
    bit                m_err;
    bit                last_iss_v;
    logic [3:0]        last_iss_slot;
    logic [3:0]        pending[$];
    int                iss_log[$];
    int                wb_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: '0};
        return s;
    endfunction

    function automatic int first_unissued();
        for (int i = 0; i < mq.size(); i++)
            if (!mq[i].issued) return i;
        return mq.size();
    endfunction

    task automatic drive(input stim_t s);
        bus.req_valid_in = s.v;
        bus.req_rw_in    = s.rw;
        bus.req_addr_in  = s.addr;
        bus.req_data_in  = s.data;
        bus.req_dest_in  = s.dest;
        bus.mem_stall_in = s.stall;
        bus.mem_ready_in = s.rdy;
        bus.mem_id_in    = s.id;
        bus.mem_data_in  = s.rdata;
    endtask

    task automatic check_model(input bit stall);
        int k  = first_unissued();
        bit ev = (k < mq.size()) && !stall;
        chk("ready", 32'(bus.req_ready_out), 32'(mq.size() < 16));
        chk("mem_valid", 32'(bus.mem_valid_out), 32'(ev));
        if (ev) begin
            chk("mem_id", 32'(bus.mem_id_out), 32'(mq[k].slot));
            chk("mem_addr", bus.mem_addr_out, mq[k].addr);
            chk("mem_data", bus.mem_data_out, mq[k].data);
            chk("mem_rw", 32'(bus.mem_rw_out), 32'(mq[k].rw));
        end
        chk("wb_valid", 32'(bus.wb_valid_out), 32'(m_wb_v));
        if (m_wb_v) begin
            chk("wb_dest", 32'(bus.wb_dest_out), 32'(m_wb_dest));
            chk("wb_data", bus.wb_data_out, m_wb_data);
        end
        chk("count", 32'(bus.count_out), 32'(mq.size()));
        chk("err", 32'(bus.err_out), 32'(m_err));
    endtask

    // Advance the model across one rising edge using the pre-edge state.
    task automatic model_edge(input stim_t s);
        int    n   = mq.size();
        int    k   = first_unissued();
        bit    ret = (n > 0) && mq[0].done;
        bit    iss = (k < n) && !s.stall;
        bit    acc = s.v && (n < 16);
        int    ri  = -1;
        ment_t e;
        if (s.rdy) begin
            for (int i = 0; i < n; i++)
                if (mq[i].slot == s.id && mq[i].issued && !mq[i].done) ri = i;
            if (ri < 0) m_err = 1'b1;
        end
        m_wb_v = ret && !mq[0].rw;
        if (ret) begin
            m_wb_dest = mq[0].dest;
            m_wb_data = mq[0].rdata;
        end
        if (ri >= 0) begin
            e = mq[ri]; e.done = 1'b1; e.rdata = s.rdata; mq[ri] = e;
        end
        last_iss_v = iss;
        if (iss) begin
            e = mq[k]; e.issued = 1'b1; mq[k] = e;
            last_iss_slot = e.slot;
        end
        if (acc) begin
            e = '{default: '0};
            e.rw = s.rw; e.addr = s.addr; e.data = s.data; e.dest = s.dest;
            e.slot = 4'(alloc_cnt % 16);
            mq.push_back(e);
            alloc_cnt++;
        end
        if (ret) void'(mq.pop_front());
    endtask

    // One clock: drive, check against the model, log, then cross the edge.
    task automatic cycle(input stim_t s);
        drive(s);
        #1;
        check_model(s.stall);
        if (bus.mem_valid_out) iss_log.push_back(int'(bus.mem_id_out));
        if (bus.wb_valid_out) wb_log.push_back(int'(bus.wb_dest_out));
        @(posedge clk);
        model_edge(s);
        if (last_iss_v) pending.push_back(last_iss_slot);
        #1;
    endtask

    task automatic do_reset();
        drive(idle());
        reset_n = 1'b0;
        #2;
        mq.delete();
        alloc_cnt = 0;
        m_wb_v = 1'b0;
        m_err = 1'b0;
        pending.delete();
        iss_log.delete();
        wb_log.delete();
        check_model(1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_traffic(input string tag, input int n_req, input int p_req,
                               input int p_stall, input int p_resp,
                               input bit in_order, input bit stores);
        int start  = alloc_cnt;
        int budget = 4000;
        while ((alloc_cnt - start < n_req || mq.size() > 0) && budget > 0) begin
            stim_t s = idle();
            if (alloc_cnt - start < n_req && int'($urandom_range(99)) < p_req) begin
                s.v    = 1'b1;
                s.rw   = stores ? 1'($urandom_range(1)) : 1'b0;
                s.addr = $urandom;
                s.data = $urandom;
                s.dest = DEST_W'($urandom);
            end
            s.stall = int'($urandom_range(99)) < p_stall;
            if (pending.size() > 0 && int'($urandom_range(99)) < p_resp) begin
                int j = in_order ? 0 : int'($urandom_range(pending.size() - 1));
                s.rdy   = 1'b1;
                s.id    = pending[j];
                s.rdata = $urandom;
                pending.delete(j);
            end
            cycle(s);
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d entries left, expected 0 within budget", tag, mq.size());
        end
        cycle(idle());
        cycle(idle());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        stim_t s;
        int    exp38[3];
        // Hand-computed single-load and single-store timelines.
        //        v  rw addr          data          dest rdy id    rdata          rdy mv id    e_addr        wb dest  wdata          cnt
        tv[0]  = '{1, 0, 32'h40,       32'h0,        5'd3, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd0};
        tv[1]  = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 1, 4'd0, 32'h40,       0, 5'd0, 32'h0,         5'd1};
        tv[2]  = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd1};
        tv[3]  = '{0, 0, 32'h0,        32'h0,        5'd0, 1, 4'd0, 32'hDEADBEEF,  1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd1};
        tv[4]  = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd1};
        tv[5]  = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        1, 5'd3, 32'hDEADBEEF,  5'd0};
        tv[6]  = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd0};
        tv[7]  = '{1, 1, 32'h80,       32'h12345678, 5'd9, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd0};
        tv[8]  = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 1, 4'd1, 32'h80,       0, 5'd0, 32'h0,         5'd1};
        tv[9]  = '{0, 0, 32'h0,        32'h0,        5'd0, 1, 4'd1, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd1};
        tv[10] = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd1};
        tv[11] = '{0, 0, 32'h0,        32'h0,        5'd0, 0, 4'd0, 32'h0,         1, 0, 4'd0, 32'h0,        0, 5'd0, 32'h0,         5'd0};

        drive(idle());
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Table-driven single load / single store.
        for (int i = 0; i < 12; i++) begin
            s = idle();
            s.v = tv[i].v; s.rw = tv[i].rw; s.addr = tv[i].addr; s.data = tv[i].data;
            s.dest = tv[i].dest; s.rdy = tv[i].rdy; s.id = tv[i].id; s.rdata = tv[i].rdata;
            drive(s);
            #1;
            chk($sformatf("tv%0d_ready", i), 32'(bus.req_ready_out), 32'(tv[i].e_ready));
            chk($sformatf("tv%0d_mv", i), 32'(bus.mem_valid_out), 32'(tv[i].e_mv));
            if (tv[i].e_mv) begin
                chk($sformatf("tv%0d_id", i), 32'(bus.mem_id_out), 32'(tv[i].e_id));
                chk($sformatf("tv%0d_addr", i), bus.mem_addr_out, tv[i].e_addr);
            end
            chk($sformatf("tv%0d_wb", i), 32'(bus.wb_valid_out), 32'(tv[i].e_wb));
            if (tv[i].e_wb) begin
                chk($sformatf("tv%0d_dest", i), 32'(bus.wb_dest_out), 32'(tv[i].e_dest));
                chk($sformatf("tv%0d_wdata", i), bus.wb_data_out, tv[i].e_wdata);
            end
            chk($sformatf("tv%0d_cnt", i), 32'(bus.count_out), 32'(tv[i].e_cnt));
            chk($sformatf("tv%0d_err", i), 32'(bus.err_out), 32'h0);
            @(posedge clk);
            #1;
        end

        // Fill to 16, hold the 17th, release one slot by answering the head.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s = idle(); s.v = 1'b1; s.addr = 32'(i * 4); s.dest = DEST_W'(i);
            cycle(s);
        end
        s = idle(); s.v = 1'b1; s.addr = 32'h1000; s.dest = 5'd17;
        repeat (3) cycle(s);
        chk("full_ready", 32'(bus.req_ready_out), 32'h0);
        chk("full_count", 32'(bus.count_out), 32'd16);
        s.rdy = 1'b1; s.id = pending[0]; s.rdata = 32'hA5A5_0000;
        void'(pending.pop_front());
        cycle(s);
        s.rdy = 1'b0;
        cycle(s);
        cycle(s);
        chk("refill_count", 32'(bus.count_out), 32'd16);
        run_traffic("full", 0, 0, 0, 50, 0, 0);

        // Responses in reverse order still write back in allocation order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.v = 1'b1; s.addr = 32'(32'h100 + i * 4); s.dest = DEST_W'(5 + i);
            cycle(s);
        end
        repeat (3) cycle(idle());
        for (int i = 2; i >= 0; i--) begin
            s = idle(); s.rdy = 1'b1; s.id = 4'(i); s.rdata = 32'(32'hC0DE_0000 + i);
            cycle(s);
        end
        repeat (5) cycle(idle());
        exp38 = '{5, 6, 7};
        chk("ooo_wb_count", 32'(wb_log.size()), 32'd3);
        for (int i = 0; i < wb_log.size() && i < 3; i++)
            chk($sformatf("ooo_wb%0d", i), 32'(wb_log[i]), 32'(exp38[i]));

        // Stall holds issue; then back-to-back in order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.v = 1'b1; s.stall = 1'b1; s.addr = 32'(32'h200 + i); s.dest = DEST_W'(i);
            cycle(s);
        end
        s = idle(); s.stall = 1'b1;
        repeat (5) cycle(s);
        chk("stall_no_issue", 32'(iss_log.size()), 32'd0);
        repeat (3) cycle(idle());
        chk("stall_issue_cnt", 32'(iss_log.size()), 32'd3);
        for (int i = 0; i < iss_log.size() && i < 3; i++)
            chk($sformatf("stall_id%0d", i), 32'(iss_log[i]), 32'(i));
        run_traffic("stall", 0, 0, 0, 100, 1, 0);

        // 40 requests: pointers wrap twice.
        do_reset();
        run_traffic("wrap", 40, 100, 0, 100, 1, 0);
        chk("wrap_issues", 32'(iss_log.size()), 32'd40);
        for (int i = 0; i < iss_log.size() && i < 40; i++)
            chk($sformatf("wrap_id%0d", i), 32'(iss_log[i]), 32'(i % 16));
        chk("wrap_wbs", 32'(wb_log.size()), 32'd40);

        // Protocol errors: response to an empty slot, reset with entries in flight.
        do_reset();
        s = idle(); s.rdy = 1'b1; s.id = 4'd5;
        cycle(s);
        repeat (3) cycle(idle());
        chk("err_sticky", 32'(bus.err_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.v = 1'b1; s.addr = 32'(32'h300 + i); s.dest = DEST_W'(i);
            cycle(s);
        end
        repeat (2) cycle(idle());
        do_reset();
        chk("rst_count", 32'(bus.count_out), 32'd0);
        chk("rst_err", 32'(bus.err_out), 32'd0);
        s = idle(); s.rdy = 1'b1; s.id = 4'd0; s.rdata = 32'hBAD0BAD0;
        cycle(s);
        repeat (3) cycle(idle());
        chk("stale_resp_err", 32'(bus.err_out), 32'd1);
        chk("stale_no_wb", 32'(wb_log.size()), 32'd0);

        // Randomized mixed traffic with out-of-order responses and stalls.
        do_reset();
        run_traffic("rand", 300, 60, 20, 35, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
